// File: rtl/btn_tx_arbiter.sv
// btn_tx_arbiter
//   Shares one UART transmitter among N_REQ conditioned request lines (one
//   tick per button press). Ticks are latched as pending requests, served in
//   round-robin order, and each grant sends one byte (CODE_BASE + index)
//   through a start/busy handshake with the transmitter.
//
//   Build option: define FIXED_PRIORITY_EN to always serve the lowest-index
//   pending requester instead of rotating.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   req_tick  in   [N_REQ] one-cycle request pulses, synchronous to clk
//   tx_busy   in   transmitter is shifting a frame
//   tx_start  out  one-cycle load strobe for the transmitter
//   tx_data   out  [8] byte to send, stable from tx_start until back in idle
//   grant_id  out  [IDW] requester currently being served
//   pending   out  [N_REQ] latched requests not yet served
//   overflow  out  sticky: tick arrived for an already-pending requester
//   tx_err    out  sticky: transmitter did not acknowledge a start in time
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | no transfer; picks the next pending requester
// S_ISSUE     | tx_start high, clears the granted pending bit
// S_WAIT_BUSY | waiting for tx_busy to rise, bounded by the ack timer
// S_WAIT_DONE | frame in flight, waiting for tx_busy to fall

module btn_tx_arbiter #(
    parameter int         N_REQ       = 4,
    parameter logic [7:0] CODE_BASE   = 8'h30,
    parameter int         ACK_TIMEOUT = 16,
    localparam int        IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_tick,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [IDW-1:0]   grant_id,
    output logic [N_REQ-1:0] pending,
    output logic             overflow,
    output logic             tx_err
);

    localparam int             CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             state_q;
    logic [IDW-1:0]     grant_id_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q;
    logic               tx_err_q;
    logic               overflow_q;
    logic [N_REQ-1:0]   pending_q;
    logic [N_REQ-1:0]   pending_d;
    logic [CW-1:0]      ack_cnt_q;
`ifndef FIXED_PRIORITY_EN
    logic [IDW-1:0]     last_q;
`endif

    logic [IDW-1:0]     scan_start;
    logic [IDW-1:0]     scan;
    logic [IDW-1:0]     sel_idx;
    logic               sel_found;
    logic [N_REQ-1:0]   grant_mask;
    logic [N_REQ-1:0]   clr_mask;
    logic [N_REQ-1:0]   retry_mask;
    logic               ack_timeout;
    logic               overflow_set;

    // Search begins just after the last requester that completed a frame.
`ifdef FIXED_PRIORITY_EN
    assign scan_start = '0;
`else
    assign scan_start = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
`endif

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan      = scan_start;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_found && pending_q[scan]) begin
                sel_found = 1'b1;
                sel_idx   = scan;
            end
            scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
        end
    end

    // The ack timer counts down from ACK_TIMEOUT-1; reaching zero with no
    // busy means the transmitter never took the byte, so the request is
    // put back for a retry.
    assign ack_timeout = (state_q == S_WAIT_BUSY) && !tx_busy && (ack_cnt_q == '0);

    assign grant_mask = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
    assign clr_mask   = (state_q == S_ISSUE) ? grant_mask : '0;
    assign retry_mask = ack_timeout ? grant_mask : '0;

    // A tick on the same edge as its clear keeps the bit set (served again).
    assign pending_d    = req_tick | (pending_q & ~clr_mask) | retry_mask;
    assign overflow_set = |(req_tick & pending_q & ~clr_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
            ack_cnt_q  <= '0;
`ifndef FIXED_PRIORITY_EN
            last_q     <= LAST_IDX;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|pending_q) begin
                        grant_id_q <= sel_idx;
                        tx_data_q  <= CODE_BASE + 8'(sel_idx);
                        tx_start_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ack_cnt_q <= CW'(ACK_TIMEOUT - 1);
                    state_q   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (ack_timeout) begin
                        tx_err_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
`ifndef FIXED_PRIORITY_EN
                        last_q  <= grant_id_q;
`endif
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign tx_err   = tx_err_q;

endmodule

// File: doc/btn_tx_arbiter.md
Name: btn_tx_arbiter

Overview:
- Shares one UART transmitter among N_REQ conditioned request lines.
- Each request line is the one-cycle tick from a synchronizer → debouncer → rising-edge-detector chain, typically one per button.
- Latches each tick as a pending request, then grants the transmitter round-robin.
- For each grant it issues a one-byte code, then sequences the start/busy handshake until the transmitter goes idle.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CODE_BASE, 8'h30, byte sent for requester i is CODE_BASE + i (mod 256).
- ACK_TIMEOUT, 16, max cycles to wait for tx_busy to rise after tx_start (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_tick  in  N_REQ  one-cycle request pulses, already synchronous to clk.
- tx_busy  in  1  high while the UART transmitter is shifting a frame.
- tx_start  out  1  one-cycle pulse, transmitter loads tx_data.
- tx_data  out  8  byte to transmit, held stable from tx_start until return to IDLE.
- grant_id  out  clog2(N_REQ) (min 1)  index of the requester currently being served.
- pending  out  N_REQ  latched, not-yet-served requests.
- overflow  out  1  sticky: a tick arrived for an already-pending requester.
- tx_err  out  1  sticky: transmitter failed to acknowledge within ACK_TIMEOUT.

Behaviour:
- Reset, asynchronous, immediate even mid-frame:
  - state=IDLE; pending=0, tx_start=0, tx_data=0, grant_id=0, overflow=0, tx_err=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
- Pending latch, per bit i, each edge:
  - If req_tick[i]: set.
  - Else if cleared by ISSUE for i: clear.
  - Set wins over clear on the same edge, so the request is kept and served again later.
- overflow sets on the edge where req_tick[i]=1 and pending[i] is already 1 and not being cleared that edge.
  - Sticky until rst.
- FSM, Moore outputs, states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE:
  - IDLE:
    - If pending≠0: select the first set bit searching last+1, last+2, … with wrap.
    - Register grant_id=sel and tx_data=CODE_BASE+sel, then go to ISSUE.
    - Else stay.
  - ISSUE:
    - tx_start=1 for exactly this one cycle; clear pending[grant_id].
    - Timeout counter=0; go to WAIT_BUSY.
  - WAIT_BUSY:
    - If tx_busy=1: go to WAIT_DONE.
    - Else if counter=ACK_TIMEOUT-1: set tx_err, re-set pending[grant_id], go to IDLE with last unchanged (retry).
    - Else counter+1.
  - WAIT_DONE:
    - If tx_busy=0: last=grant_id, go to IDLE.
    - Else stay; no timeout.
- Latency:
  - A tick sampled at edge k gives pending[i]=1 after k.
  - If IDLE, tx_start is high between edges k+1 and k+2.
  - Back-to-back grant: from the tx_busy fall seen at edge m, the next tx_start is high between edges m+1 and m+2.
- tx_busy already high while in IDLE is ignored; the handshake starts only from ISSUE.
- Ticks on multiple lines in the same cycle are all latched; service follows round-robin order.
- grant_id and tx_data change only on the IDLE→ISSUE transition.

Optional Feature:
- Macro FIXED_PRIORITY_EN.
- Defined: IDLE always selects the lowest-index set pending bit; last is neither updated nor used.
- Undefined (default): round-robin as above.
- All other behaviour is identical either way.

Test Plan:
- Reset: rst pulse mid-WAIT_DONE with pending=4'b1010 → all outputs 0 immediately; state=IDLE; no tx_start after rst falls.
- Single request: tick on req_tick[2] at edge k, tx model raises busy 1 cycle after start for 10 cycles:
  - tx_start pulses once, high between edges k+1 and k+2;
  - tx_data=8'h32, grant_id=2;
  - pending returns to 0.
- Round-robin: ticks on req 0, 1, 3 in the same cycle, then req 0 again after the first grant → grant order 0, 1, 3, 0. With FIXED_PRIORITY_EN, req 0 re-pending before req 1 is served gives 0, 0, 1, 3.
- Simultaneous set/clear: req_tick[1] high in the same cycle as ISSUE for 1 → pending[1] stays 1, overflow stays 0, requester 1 is served twice.
- Overflow: two ticks on req 3 while busy serving req 0 → overflow=1 and stays 1; req 3 is served once.
- Timeout: tx_busy held 0 → tx_err=1 after ACK_TIMEOUT cycles in WAIT_BUSY; pending[id] re-set; tx_start re-issued for the same id; tx_data unchanged.
